// File: rtl/arb_resp_demux_varlat.sv
// Bank-side round-robin arbiter with an in-order ID FIFO that steers
// variable-latency bank responses back to the master that issued each request.
module arb_resp_demux_varlat #(
    parameter int unsigned NumIn          = 4,
    parameter int unsigned ReqDataWidth   = 32,
    parameter int unsigned RespDataWidth  = 32,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned LogNumIn       = (NumIn > 1) ? $clog2(NumIn) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic [NumIn-1:0]                      req_i,
    input  logic [NumIn-1:0][ReqDataWidth-1:0]    data_i,
    output logic [NumIn-1:0]                      gnt_o,
    output logic [NumIn-1:0]                      vld_o,
    output logic [NumIn-1:0][RespDataWidth-1:0]   rdata_o,
    output logic                                  req_o,
    output logic [ReqDataWidth-1:0]               data_o,
    input  logic                                  gnt_i,
    input  logic                                  vld_i,
    input  logic [RespDataWidth-1:0]              rdata_i
);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam logic [CntW-1:0]     MaxCnt  = CntW'(MaxOutstanding);
    localparam logic [PtrW-1:0]     LastPtr = PtrW'(MaxOutstanding - 1);
    localparam logic [LogNumIn-1:0] LastIdx = LogNumIn'(NumIn - 1);
    localparam logic [LogNumIn:0]   NumInW  = (LogNumIn + 1)'(NumIn);

    logic [LogNumIn-1:0]                     rr_q, rr_d;
    logic [MaxOutstanding-1:0][LogNumIn-1:0] mem_q, mem_d;
    logic [PtrW-1:0]                         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]                         cnt_q, cnt_d;

    logic [LogNumIn-1:0] winner, head;
    logic [LogNumIn:0]   idx;
    logic                found, any_req, empty, full, pop, can_push, hs;

    // Scan from rr_q upward, wrapping at NumIn so non-power-of-2 counts stay fair.
    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        for (int unsigned k = 0; k < NumIn; k++) begin
            idx = {1'b0, rr_q} + (LogNumIn + 1)'(k);
            if (idx >= NumInW) idx = idx - NumInW;
            if (!found && req_i[idx[LogNumIn-1:0]]) begin
                winner = idx[LogNumIn-1:0];
                found  = 1'b1;
            end
        end
    end

    assign any_req  = |req_i;
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == MaxCnt);
    assign pop      = vld_i & ~empty;
    // A retiring response frees its slot in the same cycle, keeping 1 grant/cycle when full.
    assign can_push = ~full | pop;
    assign req_o    = any_req & can_push;
    assign hs       = req_o & gnt_i;
    assign data_o   = any_req ? data_i[winner] : '0;
    assign head     = mem_q[rd_ptr_q];

    for (genvar g = 0; g < NumIn; g++) begin : g_lane
        assign gnt_o[g]   = hs & (winner == LogNumIn'(g));
        assign vld_o[g]   = pop & (head == LogNumIn'(g));
        assign rdata_o[g] = rdata_i;
    end

    always_comb begin
        rr_d     = rr_q;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (hs) begin
            rr_d          = (winner == LastIdx) ? '0 : winner + 1'b1;
            mem_d[wr_ptr_q] = winner;
            wr_ptr_d      = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({hs, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q     <= '0;
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rr_q     <= rr_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

`ifndef SYNTHESIS
    // A response with nothing outstanding is dropped; flag it without stopping the run.
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (NumIn > 0 && MaxOutstanding > 0)
                else $error("arb_resp_demux_varlat: bad parameters");
            assert (!(vld_i && empty))
                else $warning("arb_resp_demux_varlat: vld_i with no outstanding request");
            assert (cnt_q <= MaxCnt)
                else $error("arb_resp_demux_varlat: outstanding count overflow");
        end
    end
`endif
endmodule

// File: tb/tb_arb_resp_demux_varlat.sv
// Randomized bench: queue-based reference model of arbitration and in-order responses,
// with a separate monitor popping expected responses whenever vld_o fires.
module tb_arb_resp_demux_varlat;
    localparam int N    = 4;
    localparam int W    = 32;
    localparam int MAXO = 2;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic [N-1:0]        req_i;
    logic [N-1:0][W-1:0] data_i;
    logic [N-1:0]        gnt_o, vld_o;
    logic [N-1:0][W-1:0] rdata_o;
    logic                req_o;
    logic [W-1:0]        data_o;
    logic                gnt_i, vld_i;
    logic [W-1:0]        rdata_i;

    arb_resp_demux_varlat #(
        .NumIn(N), .ReqDataWidth(W), .RespDataWidth(W), .MaxOutstanding(MAXO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .data_i(data_i),
        .gnt_o(gnt_o), .vld_o(vld_o), .rdata_o(rdata_o), .req_o(req_o),
        .data_o(data_o), .gnt_i(gnt_i), .vld_i(vld_i), .rdata_i(rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { int idx; logic [W-1:0] data; int due; } resp_t;

    resp_t sb[$];     // expected responses, consumed by the monitor
    resp_t bq[$];     // bank's pending responses, in issue order
    int    outst[$];  // model of outstanding master indices
    int    rr_m;
    int    cyc;
    int    lat_min, lat_max;
    int    n_chk, n_pass;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic clear_model();
        sb.delete(); bq.delete(); outst.delete();
        rr_m = 0;
    endtask

    // One clock: drive at posedge+1, check/update model at negedge, return at next posedge+1.
    // vmode: 0 bank answers when due, 1 bank silent, 2 bank forces vld_i.
    task automatic cycle(input logic [N-1:0] rq, input logic g, input int vmode,
                         output int gw, output logic [N-1:0] gs);
        int    w, idx, lat;
        logic  popm, canp, exp_req, hs;
        resp_t e;
        req_i = rq;
        gnt_i = g;
        for (int i = 0; i < N; i++) data_i[i] = $urandom;
        if (vmode == 1)      vld_i = 1'b0;
        else if (vmode == 2) vld_i = 1'b1;
        else                 vld_i = (bq.size() > 0) && (bq[0].due <= cyc);
        rdata_i = (bq.size() > 0) ? bq[0].data : $urandom;
        @(negedge clk_i);
        popm = vld_i && (outst.size() > 0);
        canp = (outst.size() < MAXO) || popm;
        w = -1;
        for (int k = 0; k < N; k++) begin
            idx = (rr_m + k) % N;
            if (rq[idx] && w < 0) w = idx;
        end
        exp_req = (w >= 0) && canp;
        hs      = exp_req && g;
        chk("req_o", req_o, exp_req);
        chk("data_o", data_o, (w >= 0) ? data_i[w] : '0);
        chk("gnt_o", gnt_o, hs ? (64'd1 << w) : 64'd0);
        if (!popm) chk("vld_idle", vld_o, 0);
        gs = gnt_o;
        gw = hs ? w : -1;
        if (popm) begin
            void'(outst.pop_front());
            void'(bq.pop_front());
        end
        if (hs) begin
            lat     = $urandom_range(lat_min, lat_max);
            e.idx   = w;
            e.data  = $urandom;
            e.due   = cyc + lat;
            outst.push_back(w);
            bq.push_back(e);
            sb.push_back(e);
            rr_m = (w + 1) % N;
        end
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic reset_dut();
        rst_ni = 1'b0;
        req_i = '0; gnt_i = 1'b0; vld_i = 1'b0; rdata_i = '0; data_i = '0;
        clear_model();
        #2;
        chk("rst_req_o", req_o, 0);
        chk("rst_gnt_o", gnt_o, 0);
        chk("rst_vld_o", vld_o, 0);
        #1;
        rst_ni = 1'b1;
    endtask

    // Monitor: every DUT response must match the oldest expected one.
    always @(negedge clk_i) begin
        resp_t e;
        if (vld_o != '0) begin
            if (sb.size() == 0) chk("vld_unexpected", vld_o, 0);
            else begin
                e = sb.pop_front();
                chk("vld_dst", vld_o, 64'd1 << e.idx);
                chk("rdata_dst", rdata_o[e.idx], e.data);
                chk("rdata_bcast", rdata_o[(e.idx + 1) % N], e.data);
            end
        end
    end

    initial begin
        int           gw;
        logic [N-1:0] gs, rs;
        n_chk = 0; n_pass = 0; cyc = 0;
        rst_ni = 1'b0;
        req_i = '0; gnt_i = 1'b0; vld_i = 1'b0; rdata_i = '0; data_i = '0;
        clear_model();
        @(posedge clk_i);
        #1;

        // All masters requesting, latency 2: grants rotate 0,1,2,3,0 at full rate.
        reset_dut();
        lat_min = 2; lat_max = 2;
        for (int k = 0; k < 5; k++) begin
            cycle(4'b1111, 1'b1, 0, gw, gs);
            chk("t1_rotate", gs, 4'b0001 << (k % 4));
        end
        repeat (3) cycle('0, 1'b0, 0, gw, gs);

        // Sparse requesters: 1, 3, then wrap back to 1.
        reset_dut();
        lat_min = 1; lat_max = 1;
        cycle(4'b1010, 1'b1, 0, gw, gs); chk("t2_first", gs, 4'b0010);
        cycle(4'b1010, 1'b1, 0, gw, gs); chk("t2_second", gs, 4'b1000);
        cycle(4'b1010, 1'b1, 0, gw, gs); chk("t2_wrap", gs, 4'b0010);
        repeat (2) cycle('0, 1'b0, 0, gw, gs);

        // Fill the ID FIFO, stall, then a response frees room in the same cycle.
        reset_dut();
        cycle(4'b1111, 1'b1, 1, gw, gs); chk("t3_g0", gs, 4'b0001);
        cycle(4'b1111, 1'b1, 1, gw, gs); chk("t3_g1", gs, 4'b0010);
        cycle(4'b1111, 1'b1, 1, gw, gs); chk("t3_full_gnt", gs, 4'b0000);
        cycle(4'b1111, 1'b1, 2, gw, gs); chk("t3_refill", gs, 4'b0100);
        repeat (4) cycle('0, 1'b0, 0, gw, gs);

        // Bank withholds grant: request persists, then master 2 wins.
        repeat (3) begin
            cycle(4'b0100, 1'b0, 0, gw, gs); chk("t4_stall", gs, 4'b0000);
        end
        cycle(4'b0100, 1'b1, 0, gw, gs); chk("t4_grant", gs, 4'b0100);
        repeat (3) cycle('0, 1'b0, 0, gw, gs);

        // Stray response with nothing outstanding is ignored.
        cycle('0, 1'b0, 2, gw, gs);

        // Asynchronous reset with two outstanding entries.
        cycle(4'b1111, 1'b1, 1, gw, gs);
        cycle(4'b1111, 1'b1, 1, gw, gs);
        rst_ni = 1'b0;
        clear_model();
        req_i = 4'b1111; gnt_i = 1'b1; vld_i = 1'b1;
        #1;
        chk("t6_req_flushed", req_o, 1);
        chk("t6_rr_cleared", gnt_o, 4'b0001);
        chk("t6_no_vld", vld_o, 0);
        req_i = '0; gnt_i = 1'b0; vld_i = 1'b0;
        #1;
        rst_ni = 1'b1;
        cycle('0, 1'b0, 2, gw, gs);

        // Randomized traffic: masters hold until granted, occasionally withdraw.
        lat_min = 1; lat_max = 4;
        rs = '0;
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!rs[i]) rs[i] = ($urandom_range(0, 99) < 40);
                else if ($urandom_range(0, 99) < 5) rs[i] = 1'b0;
            end
            cycle(rs, ($urandom_range(0, 99) < 70), 0, gw, gs);
            if (gw >= 0) rs[gw] = 1'b0;
        end
        for (int t = 0; t < 50 && bq.size() > 0; t++) cycle('0, 1'b0, 0, gw, gs);
        cycle('0, 1'b0, 0, gw, gs);
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
